// File: rtl/md4_block_if.sv
// Handshake and data bundle between the NT-hash sequencer and the MD4 compression engine.
// The sequencer owns the master side; md4_block owns the slave side.
interface md4_block_if;
  logic         irdy;
  logic [31:0]  in_a;
  logic [31:0]  in_b;
  logic [31:0]  in_c;
  logic [31:0]  in_d;
  logic [511:0] data;
  logic         ordy;
  logic [31:0]  out_a;
  logic [31:0]  out_b;
  logic [31:0]  out_c;
  logic [31:0]  out_d;

  modport master (
    output irdy, in_a, in_b, in_c, in_d, data,
    input  ordy, out_a, out_b, out_c, out_d
  );

  modport slave (
    input  irdy, in_a, in_b, in_c, in_d, data,
    output ordy, out_a, out_b, out_c, out_d
  );
endinterface

// File: rtl/md4_block.sv
// Iterative MD4 compression: one step per clock, 48 steps plus a final feed-forward cycle.
// A rising edge on irdy starts a run; ordy and out_* hold the last result until the next start.
module md4_block (
  input  logic        clk,
  input  logic        rst,
  md4_block_if.slave  bus
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] BUSY   = 2'd1;
  localparam logic [1:0] FINISH = 2'd2;

  localparam logic [31:0] K_ROUND2 = 32'h5A827999;
  localparam logic [31:0] K_ROUND3 = 32'h6ED9EBA1;

  logic [1:0]   state_q, state_d;
  logic [5:0]   step_q, step_d;
  logic         irdyPrev_q, irdyPrev_d;
  logic [31:0]  a_q, b_q, c_q, d_q;
  logic [31:0]  a_d, b_d, c_d, d_d;
  logic [31:0]  a0_q, b0_q, c0_q, d0_q;
  logic [31:0]  a0_d, b0_d, c0_d, d0_d;
  logic [511:0] blk_q, blk_d;
  logic [31:0]  outA_q, outB_q, outC_q, outD_q;
  logic [31:0]  outA_d, outB_d, outC_d, outD_d;
  logic         ordy_q, ordy_d;

  logic         start;
  logic [1:0]   round;
  logic [3:0]   idx;
  logic [3:0]   wordSel;
  logic [4:0]   shamt;
  logic [31:0]  fVal;
  logic [31:0]  kConst;
  logic [31:0]  xWord;
  logic [31:0]  sum;
  logic [63:0]  rotWide;
  logic [31:0]  stepT;

  assign start = bus.irdy & ~irdyPrev_q;
  assign xWord = blk_q[{wordSel, 5'd0} +: 32];

  // Round function, message word order and shift amount for the current step.
  // Round 2 visits words column-wise; round 3 visits them in bit-reversed order.
  always_comb begin
    round   = step_q[5:4];
    idx     = step_q[3:0];
    fVal    = '0;
    kConst  = '0;
    wordSel = idx;
    shamt   = 5'd3;
    case (round)
      2'd0: begin
        fVal    = (b_q & c_q) | (~b_q & d_q);
        kConst  = '0;
        wordSel = idx;
        case (idx[1:0])
          2'd0:    shamt = 5'd3;
          2'd1:    shamt = 5'd7;
          2'd2:    shamt = 5'd11;
          default: shamt = 5'd19;
        endcase
      end
      2'd1: begin
        fVal    = (b_q & c_q) | (b_q & d_q) | (c_q & d_q);
        kConst  = K_ROUND2;
        wordSel = {idx[1:0], idx[3:2]};
        case (idx[1:0])
          2'd0:    shamt = 5'd3;
          2'd1:    shamt = 5'd5;
          2'd2:    shamt = 5'd9;
          default: shamt = 5'd13;
        endcase
      end
      default: begin
        fVal    = b_q ^ c_q ^ d_q;
        kConst  = K_ROUND3;
        wordSel = {idx[0], idx[1], idx[2], idx[3]};
        case (idx[1:0])
          2'd0:    shamt = 5'd3;
          2'd1:    shamt = 5'd9;
          2'd2:    shamt = 5'd11;
          default: shamt = 5'd15;
        endcase
      end
    endcase
    sum     = a_q + fVal + xWord + kConst;
    rotWide = {sum, sum} << shamt;
    stepT   = rotWide[63:32];
  end

  // Sequencer: latch inputs on start, run 48 steps, then add the saved state back in.
  always_comb begin
    state_d    = state_q;
    step_d     = step_q;
    irdyPrev_d = bus.irdy;
    a_d = a_q;   b_d = b_q;   c_d = c_q;   d_d = d_q;
    a0_d = a0_q; b0_d = b0_q; c0_d = c0_q; d0_d = d0_q;
    blk_d  = blk_q;
    outA_d = outA_q; outB_d = outB_q; outC_d = outC_q; outD_d = outD_q;
    ordy_d = ordy_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          a0_d = bus.in_a; b0_d = bus.in_b; c0_d = bus.in_c; d0_d = bus.in_d;
          a_d  = bus.in_a; b_d  = bus.in_b; c_d  = bus.in_c; d_d  = bus.in_d;
          blk_d   = bus.data;
          ordy_d  = 1'b0;
          step_d  = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        a_d    = d_q;
        b_d    = stepT;
        c_d    = b_q;
        d_d    = c_q;
        step_d = step_q + 6'd1;
        if (step_q == 6'd47) begin
          state_d = FINISH;
        end
      end
      FINISH: begin
        outA_d  = a_q + a0_q;
        outB_d  = b_q + b0_q;
        outC_d  = c_q + c0_q;
        outD_d  = d_q + d0_q;
        ordy_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      step_q     <= '0;
      irdyPrev_q <= 1'b0;
      a_q  <= '0; b_q  <= '0; c_q  <= '0; d_q  <= '0;
      a0_q <= '0; b0_q <= '0; c0_q <= '0; d0_q <= '0;
      blk_q  <= '0;
      outA_q <= '0; outB_q <= '0; outC_q <= '0; outD_q <= '0;
      ordy_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      step_q     <= step_d;
      irdyPrev_q <= irdyPrev_d;
      a_q  <= a_d;  b_q  <= b_d;  c_q  <= c_d;  d_q  <= d_d;
      a0_q <= a0_d; b0_q <= b0_d; c0_q <= c0_d; d0_q <= d0_d;
      blk_q  <= blk_d;
      outA_q <= outA_d; outB_q <= outB_d; outC_q <= outC_d; outD_q <= outD_d;
      ordy_q <= ordy_d;
    end
  end

  assign bus.ordy  = ordy_q;
  assign bus.out_a = outA_q;
  assign bus.out_b = outB_q;
  assign bus.out_c = outC_q;
  assign bus.out_d = outD_q;

endmodule

// File: tb/tb_md4_block.sv
// Testbench for md4_block: known MD4 vectors plus random blocks against a loop-based MD4 model.
module tb_md4_block;
  logic clk = 1'b0;
  logic rst;

  md4_block_if bus();

  md4_block dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  localparam logic [127:0] IV = {32'h67452301, 32'hefcdab89, 32'h98badcfe, 32'h10325476};
  localparam logic [127:0] EMPTY_OUT = {32'he0cfd631, 32'h31e96ad1, 32'hd7593cb7, 32'hc089c0e0};
  localparam logic [127:0] ABC_OUT   = {32'h7a0148a4, 32'h52d821af, 32'he80ac15f, 32'h9d72a67a};
  localparam logic [127:0] PASS_OUT  = {32'heaf74688, 32'h17b18fee, 32'hd8bd06ad, 32'h6c58b730};

  // Reference MD4 compression written straight from the round tables.
  function automatic logic [127:0] md4Ref(input logic [127:0] st, input logic [511:0] blk);
    int kr2[16] = '{0, 4, 8, 12, 1, 5, 9, 13, 2, 6, 10, 14, 3, 7, 11, 15};
    int kr3[16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};
    int s1[4]   = '{3, 7, 11, 19};
    int s2[4]   = '{3, 5, 9, 13};
    int s3[4]   = '{3, 9, 11, 15};
    logic [31:0] x[16];
    logic [31:0] a, b, c, d, f, kc, sum, t;
    int k, s;
    for (int i = 0; i < 16; i++) x[i] = blk[32*i +: 32];
    {a, b, c, d} = st;
    for (int j = 0; j < 48; j++) begin
      if (j < 16) begin
        f = (b & c) | (~b & d); kc = 32'h0;        k = j;           s = s1[j % 4];
      end else if (j < 32) begin
        f = (b & c) | (b & d) | (c & d); kc = 32'h5A827999; k = kr2[j - 16]; s = s2[j % 4];
      end else begin
        f = b ^ c ^ d;          kc = 32'h6ED9EBA1; k = kr3[j - 32]; s = s3[j % 4];
      end
      sum = a + f + x[k] + kc;
      t = (sum << s) | (sum >> (32 - s));
      a = d; d = c; c = b; b = t;
    end
    return {st[127:96] + a, st[95:64] + b, st[63:32] + c, st[31:0] + d};
  endfunction

  function automatic logic [127:0] outVec();
    return {bus.out_a, bus.out_b, bus.out_c, bus.out_d};
  endfunction

  function automatic logic [511:0] knownBlock(input int which);
    logic [511:0] blk;
    blk = '0;
    case (which)
      0: blk[31:0] = 32'h00000080;
      1: begin
        blk[31:0]       = 32'h80636261;
        blk[14*32 +: 32] = 32'h00000018;
      end
      default: begin
        blk[0*32 +: 32]  = 32'h00610070;
        blk[1*32 +: 32]  = 32'h00730073;
        blk[2*32 +: 32]  = 32'h006f0077;
        blk[3*32 +: 32]  = 32'h00640072;
        blk[4*32 +: 32]  = 32'h00000080;
        blk[14*32 +: 32] = 32'h00000080;
      end
    endcase
    return blk;
  endfunction

  // Drives a start with irdy held for 'hold' rising edges; returns at the negedge after edge hold-1.
  task automatic launch(input logic [127:0] st, input logic [511:0] blk, input int hold);
    @(negedge clk);
    {bus.in_a, bus.in_b, bus.in_c, bus.in_d} = st;
    bus.data = blk;
    bus.irdy = 1'b1;
    repeat (hold) @(posedge clk);
    @(negedge clk);
    bus.irdy = 1'b0;
  endtask

  // Counts rising edges past the start edge until ordy is seen, bounded.
  task automatic waitOrdy(input int startCount, output int lat);
    lat = startCount;
    while (bus.ordy !== 1'b1 && lat < 200) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.irdy = 1'b0;
    {bus.in_a, bus.in_b, bus.in_c, bus.in_d} = '0;
    bus.data = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.ordy !== 1'b0) begin
      errors++; $display("[TB] FAIL reset.ordy got %b want 0", bus.ordy);
    end
    checks++;
    if (outVec() !== 128'h0) begin
      errors++; $display("[TB] FAIL reset.out got %h want 0", outVec());
    end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.ordy !== 1'b0) begin
      errors++; $display("[TB] FAIL reset.idle_ordy got %b want 0", bus.ordy);
    end
  endtask

  task automatic test_known_vectors();
    logic [127:0] want[3];
    string names[3];
    int lat;
    want[0] = EMPTY_OUT; want[1] = ABC_OUT; want[2] = PASS_OUT;
    names[0] = "empty"; names[1] = "abc"; names[2] = "password";
    for (int v = 0; v < 3; v++) begin
      launch(IV, knownBlock(v), 1);
      waitOrdy(0, lat);
      checks++;
      if (lat !== 49) begin
        errors++; $display("[TB] FAIL %s.latency got %0d want 49", names[v], lat);
      end
      checks++;
      if (outVec() !== want[v]) begin
        errors++; $display("[TB] FAIL %s.out got %h want %h", names[v], outVec(), want[v]);
      end
    end
  endtask

  task automatic test_random_blocks();
    logic [127:0] st;
    logic [511:0] blk;
    logic [127:0] exp;
    int hold, lat;
    for (int n = 0; n < 8; n++) begin
      st = {$urandom, $urandom, $urandom, $urandom};
      for (int i = 0; i < 16; i++) blk[32*i +: 32] = $urandom;
      hold = $urandom_range(1, 3);
      exp = md4Ref(st, blk);
      launch(st, blk, hold);
      // Inputs scrambled while busy must not affect the result.
      {bus.in_a, bus.in_b, bus.in_c, bus.in_d} = {$urandom, $urandom, $urandom, $urandom};
      for (int i = 0; i < 16; i++) bus.data[32*i +: 32] = $urandom;
      waitOrdy(hold - 1, lat);
      checks++;
      if (lat !== 49) begin
        errors++; $display("[TB] FAIL random%0d.latency got %0d want 49", n, lat);
      end
      checks++;
      if (outVec() !== exp) begin
        errors++; $display("[TB] FAIL random%0d.out got %h want %h", n, outVec(), exp);
      end
    end
  endtask

  task automatic test_irdy_held();
    int lat, drops;
    launch(IV, knownBlock(0), 3);
    waitOrdy(2, lat);
    checks++;
    if (lat !== 49) begin
      errors++; $display("[TB] FAIL held.latency got %0d want 49", lat);
    end
    checks++;
    if (outVec() !== EMPTY_OUT) begin
      errors++; $display("[TB] FAIL held.out got %h want %h", outVec(), EMPTY_OUT);
    end
    drops = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (bus.ordy !== 1'b1) drops++;
    end
    checks++;
    if (drops !== 0) begin
      errors++; $display("[TB] FAIL held.retrigger got %0d ordy-low cycles want 0", drops);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    launch(IV, knownBlock(1), 1);
    waitOrdy(0, lat);
    checks++;
    if (outVec() !== ABC_OUT) begin
      errors++; $display("[TB] FAIL b2b.first got %h want %h", outVec(), ABC_OUT);
    end
    launch(IV, knownBlock(0), 1);
    checks++;
    if (bus.ordy !== 1'b0) begin
      errors++; $display("[TB] FAIL b2b.ordy_drop got %b want 0", bus.ordy);
    end
    checks++;
    if (outVec() !== ABC_OUT) begin
      errors++; $display("[TB] FAIL b2b.hold_start got %h want %h", outVec(), ABC_OUT);
    end
    repeat (24) @(posedge clk);
    @(negedge clk);
    checks++;
    if (outVec() !== ABC_OUT) begin
      errors++; $display("[TB] FAIL b2b.hold_mid got %h want %h", outVec(), ABC_OUT);
    end
    waitOrdy(24, lat);
    checks++;
    if (lat !== 49) begin
      errors++; $display("[TB] FAIL b2b.latency got %0d want 49", lat);
    end
    checks++;
    if (outVec() !== EMPTY_OUT) begin
      errors++; $display("[TB] FAIL b2b.second got %h want %h", outVec(), EMPTY_OUT);
    end
  endtask

  task automatic test_reset_midrun();
    int lat;
    launch(IV, knownBlock(1), 1);
    repeat (20) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (bus.ordy !== 1'b0) begin
      errors++; $display("[TB] FAIL midrst.ordy got %b want 0", bus.ordy);
    end
    checks++;
    if (outVec() !== 128'h0) begin
      errors++; $display("[TB] FAIL midrst.out got %h want 0", outVec());
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (60) @(negedge clk);
    checks++;
    if (bus.ordy !== 1'b0) begin
      errors++; $display("[TB] FAIL midrst.no_restart got %b want 0", bus.ordy);
    end
    launch(IV, knownBlock(2), 1);
    waitOrdy(0, lat);
    checks++;
    if (lat !== 49) begin
      errors++; $display("[TB] FAIL midrst.latency got %0d want 49", lat);
    end
    checks++;
    if (outVec() !== PASS_OUT) begin
      errors++; $display("[TB] FAIL midrst.out got %h want %h", outVec(), PASS_OUT);
    end
  endtask

  initial begin
    test_reset();
    test_known_vectors();
    test_random_blocks();
    test_irdy_held();
    test_back_to_back();
    test_reset_midrun();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
